// File: rtl/pad_input_filter_pkg.sv
// Shared types and constants for the pad input conditioning stage.
package pad_input_filter_pkg;

  typedef enum logic [1:0] {
    RESET,
    SETTLE,
    CAPTURE,
    DONE
  } strap_state_e;

  localparam int unsigned PADCFG_FILT_EN_BIT = 1;
  localparam int unsigned GLITCH_CNT_W       = 16;

endpackage

// File: rtl/pad_input_filter_debounce.sv
// Per-pad conditioning: synchroniser, debounce counter, conditioned level
// register and registered rise/fall edge pulses.
module pad_debounce_cell #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pad,
  input  logic                 filt_en,
  input  logic [DEB_CNT_W-1:0] limit,
  output logic                 level,
  output logic                 rise,
  output logic                 fall,
  output logic                 glitch
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [DEB_CNT_W-1:0]   cnt;
  logic [DEB_CNT_W:0]     cnt_inc;
  logic                   hit;
  logic                   level_q;

  assign s       = sync_q[SYNC_STAGES-1];
  // One extra bit so counter+1 at all-ones still compares correctly.
  assign cnt_inc = {1'b0, cnt} + (DEB_CNT_W + 1)'(1);
  assign hit     = cnt_inc >= {1'b0, limit};
  // A filtered pad dropping a nonzero count without toggling rejected a glitch.
  assign glitch  = filt_en && (cnt != '0) && (s == level);

  // Shift the asynchronous pad through the synchroniser chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
    end
  end

  // Debounce: follow s directly when unfiltered, else require a stable run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (!filt_en) begin
      cnt   <= '0;
      level <= s;
    end else if (s != level) begin
      if (hit) begin
        level <= ~level;
        cnt   <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt_inc[DEB_CNT_W-1:0];
      end
    end else begin
      cnt <= '0;
    end
  end

  // Registered one-cycle pulses on each change of the conditioned level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      level_q <= level;
      rise    <= level & ~level_q;
      fall    <= ~level & level_q;
    end
  end

endmodule

// File: rtl/pad_input_filter.sv
// Pad input conditioning between the pad ring and the core io_in bus:
// per-pad synchronise/debounce/edge detect, boot strap capture after reset,
// and an optional rejected-glitch counter enabled by the macro
// PAD_INPUT_FILTER_GLITCH_CNT_EN.
module pad_input_filter
  import pad_input_filter_pkg::*;
#(
  parameter int unsigned N_IO              = 48,
  parameter int unsigned NBIT_PADCFG       = 6,
  parameter int unsigned SYNC_STAGES       = 2,
  parameter int unsigned DEB_CNT_W         = 8,
  parameter int unsigned STRAP_SETTLE      = 16,
  parameter int unsigned STRAP_BOOTSEL_IDX = 45,
  parameter int unsigned STRAP_STM_IDX     = 44
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [N_IO-1:0]               pad_in_i,
  input  logic [N_IO*NBIT_PADCFG-1:0]   pad_cfg_i,
  input  logic [DEB_CNT_W-1:0]          deb_limit_i,
  output logic [N_IO-1:0]               io_in_o,
  output logic [N_IO-1:0]               rise_o,
  output logic [N_IO-1:0]               fall_o,
  output logic                          bootsel_o,
  output logic                          stm_o,
  output logic                          strap_valid_o
`ifdef PAD_INPUT_FILTER_GLITCH_CNT_EN
  ,
  input  logic                          glitch_clr_i,
  output logic [GLITCH_CNT_W-1:0]       glitch_cnt_o
`endif
);

  localparam int unsigned SETTLE_W = $clog2(STRAP_SETTLE + 1);

  logic [DEB_CNT_W-1:0] limit;
  logic [N_IO-1:0]      glitch;
  logic                 unused_cfg;
  strap_state_e         state;
  logic [SETTLE_W-1:0]  settle_cnt;

  // A threshold of zero behaves like one (no extra delay).
  assign limit      = (deb_limit_i == '0) ? DEB_CNT_W'(1) : deb_limit_i;
  assign unused_cfg = ^pad_cfg_i;

  for (genvar i = 0; i < N_IO; i++) begin : g_pad
    pad_debounce_cell #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_CNT_W  (DEB_CNT_W)
    ) u_cell (
      .clk    (clk_i),
      .rst    (rst_i),
      .pad    (pad_in_i[i]),
      .filt_en(pad_cfg_i[i*NBIT_PADCFG + PADCFG_FILT_EN_BIT]),
      .limit  (limit),
      .level  (io_in_o[i]),
      .rise   (rise_o[i]),
      .fall   (fall_o[i]),
      .glitch (glitch[i])
    );
  end

  // Strap capture: wait for pads to settle after reset, latch once, hold.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= RESET;
      settle_cnt    <= '0;
      bootsel_o     <= 1'b0;
      stm_o         <= 1'b0;
      strap_valid_o <= 1'b0;
    end else begin
      case (state)
        RESET: begin
          settle_cnt <= '0;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_W'(STRAP_SETTLE - 1)) begin
            state <= CAPTURE;
          end else begin
            settle_cnt <= settle_cnt + SETTLE_W'(1);
          end
        end
        CAPTURE: begin
          bootsel_o     <= io_in_o[STRAP_BOOTSEL_IDX];
          stm_o         <= io_in_o[STRAP_STM_IDX];
          strap_valid_o <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= RESET;
        end
      endcase
    end
  end

`ifdef PAD_INPUT_FILTER_GLITCH_CNT_EN
  localparam int unsigned POP_W = $clog2(N_IO + 1);

  logic [POP_W-1:0]        glitch_pop;
  logic [GLITCH_CNT_W:0]   glitch_sum;

  // Count how many pads rejected a glitch this cycle.
  always_comb begin
    glitch_pop = '0;
    for (int unsigned k = 0; k < N_IO; k++) begin
      glitch_pop = glitch_pop + POP_W'(glitch[k]);
    end
  end

  assign glitch_sum = {1'b0, glitch_cnt_o} + (GLITCH_CNT_W + 1)'(glitch_pop);

  // Saturating glitch counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      glitch_cnt_o <= '0;
    end else if (glitch_clr_i) begin
      glitch_cnt_o <= '0;
    end else if (glitch_sum[GLITCH_CNT_W]) begin
      glitch_cnt_o <= '1;
    end else begin
      glitch_cnt_o <= glitch_sum[GLITCH_CNT_W-1:0];
    end
  end
`else
  logic unused_glitch;
  assign unused_glitch = ^glitch;
`endif

endmodule

// File: tb/tb_pad_input_filter.sv
// Self-checking bench for pad_input_filter: a table of single-pad pulse
// vectors with expected toggle cycles, plus hand sequences for straps,
// resets, mid-count config changes and the optional glitch counter.
module tb_pad_input_filter;

  localparam int N_IO   = 48;
  localparam int NB     = 6;
  localparam int W      = 8;
  localparam int SETTLE = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_IO-1:0]   pad_in;
  logic [N_IO*NB-1:0] pad_cfg;
  logic [W-1:0]      deb_limit;
  logic [N_IO-1:0]   io_in;
  logic [N_IO-1:0]   rise;
  logic [N_IO-1:0]   fall;
  logic              bootsel;
  logic              stm;
  logic              strap_valid;
`ifdef PAD_INPUT_FILTER_GLITCH_CNT_EN
  logic              glitch_clr;
  logic [15:0]       glitch_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pad_input_filter #(
    .N_IO             (N_IO),
    .NBIT_PADCFG      (NB),
    .SYNC_STAGES      (2),
    .DEB_CNT_W        (W),
    .STRAP_SETTLE     (SETTLE),
    .STRAP_BOOTSEL_IDX(45),
    .STRAP_STM_IDX    (44)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .pad_in_i     (pad_in),
    .pad_cfg_i    (pad_cfg),
    .deb_limit_i  (deb_limit),
    .io_in_o      (io_in),
    .rise_o       (rise),
    .fall_o       (fall),
    .bootsel_o    (bootsel),
    .stm_o        (stm),
    .strap_valid_o(strap_valid)
`ifdef PAD_INPUT_FILTER_GLITCH_CNT_EN
    ,
    .glitch_clr_i (glitch_clr),
    .glitch_cnt_o (glitch_cnt)
`endif
  );

  // Pad pulse vector: tick numbers count posedges after the pad goes high.
  typedef struct {
    int pad;
    bit en;
    int limit;
    int width;
    int exp_hi;
    int exp_lo;
  } vec_t;

  typedef struct {
    int hi;
    int lo;
    int rise_at;
    int fall_at;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    exp_t g;
    int hi = -1, lo = -1, rt = -1, ft = -1, rc = 0, fc = 0;
    logic [N_IO-1:0] mask;
    pad_cfg = '0;
    pad_cfg[v.pad*NB +: NB] = v.en ? 6'b000010 : 6'b111101;
    deb_limit = W'(v.limit);
    pad_in = '0;
    repeat (20) tick();
    e.hi      = v.exp_hi;
    e.lo      = v.exp_lo;
    e.rise_at = (v.exp_hi < 0) ? -1 : v.exp_hi + 1;
    e.fall_at = (v.exp_lo < 0) ? -1 : v.exp_lo + 1;
    sb.push_back(e);
    pad_in[v.pad] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == v.width) pad_in[v.pad] = 1'b0;
      if (io_in[v.pad] && hi < 0) hi = k;
      if (!io_in[v.pad] && hi >= 0 && lo < 0) lo = k;
      if (rise[v.pad]) begin rc++; if (rt < 0) rt = k; end
      if (fall[v.pad]) begin fc++; if (ft < 0) ft = k; end
    end
    g = sb.pop_front();
    mask = '1;
    mask[v.pad] = 1'b0;
    check($sformatf("v%0d_hi", idx), hi, g.hi);
    check($sformatf("v%0d_lo", idx), lo, g.lo);
    check($sformatf("v%0d_rise_at", idx), rt, g.rise_at);
    check($sformatf("v%0d_fall_at", idx), ft, g.fall_at);
    check($sformatf("v%0d_rise_cnt", idx), rc, (g.hi < 0) ? 0 : 1);
    check($sformatf("v%0d_fall_cnt", idx), fc, (g.lo < 0) ? 0 : 1);
    check($sformatf("v%0d_others", idx), io_in & mask, 0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[10];
    int   t_valid;

    vecs[0] = '{5,  1'b0, 4, 6,  3,  9};
    vecs[1] = '{10, 1'b1, 4, 3,  -1, -1};
    vecs[2] = '{10, 1'b1, 4, 10, 6,  16};
    vecs[3] = '{7,  1'b1, 0, 5,  3,  8};
    vecs[4] = '{7,  1'b1, 1, 1,  3,  4};
    vecs[5] = '{20, 1'b1, 2, 1,  -1, -1};
    vecs[6] = '{20, 1'b1, 2, 2,  4,  6};
    vecs[7] = '{47, 1'b1, 8, 7,  -1, -1};
    vecs[8] = '{0,  1'b1, 8, 8,  10, 18};
    vecs[9] = '{3,  1'b0, 8, 2,  3,  5};

    // Reset holds every output low even with all pads high.
    rst       = 1'b1;
    pad_in    = '1;
    pad_cfg   = '0;
    deb_limit = '0;
`ifdef PAD_INPUT_FILTER_GLITCH_CNT_EN
    glitch_clr = 1'b0;
`endif
    repeat (3) tick();
    check("rst_io", io_in, 0);
    check("rst_rise", rise, 0);
    check("rst_fall", fall, 0);
    check("rst_bootsel", bootsel, 0);
    check("rst_stm", stm, 0);
    check("rst_valid", strap_valid, 0);

    // Strap capture after release.
    pad_in     = '0;
    pad_in[45] = 1'b1;
    tick();
    rst = 1'b0;
    t_valid = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (strap_valid && t_valid < 0) t_valid = k;
    end
    check("strap_valid_cycle", t_valid, SETTLE + 2);
    check("strap_bootsel", bootsel, 1);
    check("strap_stm", stm, 0);
    pad_in[45] = 1'b0;
    repeat (10) tick();
    check("strap_bootsel_hold", bootsel, 1);
    check("strap_valid_hold", strap_valid, 1);

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Disabling the filter mid-count passes s through on the next edge.
    pad_cfg = '0;
    pad_cfg[12*NB +: NB] = 6'b000010;
    deb_limit = 8'd8;
    pad_in = '0;
    repeat (20) tick();
    pad_in[12] = 1'b1;
    repeat (5) tick();
    check("dis_mid_pre", io_in[12], 0);
    pad_cfg[12*NB + 1] = 1'b0;
    tick();
    check("dis_mid_post", io_in[12], 1);
    pad_in[12] = 1'b0;

    // Lowering the threshold mid-count takes effect immediately.
    pad_cfg = '0;
    pad_cfg[13*NB +: NB] = 6'b000010;
    deb_limit = 8'd10;
    repeat (20) tick();
    pad_in[13] = 1'b1;
    repeat (5) tick();
    check("lim_low_pre", io_in[13], 0);
    deb_limit = 8'd2;
    tick();
    check("lim_low_post", io_in[13], 1);
    pad_in[13] = 1'b0;

`ifdef PAD_INPUT_FILTER_GLITCH_CNT_EN
    pad_cfg = '0;
    pad_cfg[10*NB +: NB] = 6'b000010;
    pad_cfg[11*NB +: NB] = 6'b000010;
    deb_limit = 8'd4;
    repeat (20) tick();
    glitch_clr = 1'b1;
    tick();
    glitch_clr = 1'b0;
    tick();
    check("glitch_cleared", glitch_cnt, 0);
    pad_in[10] = 1'b1;
    repeat (3) tick();
    pad_in[10] = 1'b0;
    repeat (8) tick();
    check("glitch_one", glitch_cnt, 1);
    check("glitch_io", io_in[10], 0);
    pad_in[10] = 1'b1;
    pad_in[11] = 1'b1;
    repeat (3) tick();
    pad_in[10] = 1'b0;
    pad_in[11] = 1'b0;
    repeat (8) tick();
    check("glitch_pop", glitch_cnt, 3);
    pad_in[10] = 1'b1;
    repeat (3) tick();
    pad_in[10] = 1'b0;
    repeat (2) tick();
    glitch_clr = 1'b1;
    tick();
    glitch_clr = 1'b0;
    check("glitch_clr_prio", glitch_cnt, 0);
    repeat (4) tick();
    check("glitch_clr_hold", glitch_cnt, 0);
`endif

    // Reset mid-debounce, then re-capture with new strap values.
    pad_cfg = '0;
    pad_cfg[10*NB +: NB] = 6'b000010;
    deb_limit = 8'd8;
    pad_in = '0;
    pad_in[44] = 1'b1;
    repeat (20) tick();
    pad_in[10] = 1'b1;
    repeat (4) tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_io", io_in, 0);
    check("arst_bootsel", bootsel, 0);
    check("arst_valid", strap_valid, 0);
    check("arst_rise", rise, 0);
    tick();
    rst = 1'b0;
    t_valid = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (strap_valid && t_valid < 0) t_valid = k;
    end
    check("recap_valid_cycle", t_valid, SETTLE + 2);
    check("recap_bootsel", bootsel, 0);
    check("recap_stm", stm, 1);

    // Reset after DONE clears straps without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("arst_done_valid", strap_valid, 0);
    check("arst_done_stm", stm, 0);
    check("arst_done_io", io_in, 0);
    check("arst_done_fall", fall, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pad_input_filter.md
Name: pad_input_filter

Overview:
- Parametrised input-conditioning stage between the FPGA pad layer and core_v_mcu io_in_i.
- Per pad: N-stage synchroniser, then an optional per-pad debounce filter, then one-cycle rise/fall edge pulses.
- Captures boot straps (bootsel, stm) once after reset release through a small settle/capture FSM.
- Adds metastability protection and glitch rejection; the current direct pad-to-core input path has neither.

Parameters:
- N_IO, 48: number of pads.
- NBIT_PADCFG, 6: width of each pad-config word.
- SYNC_STAGES, 2: synchroniser flops per pad; minimum 2.
- DEB_CNT_W, 8: width of the debounce counter and of the threshold.
- STRAP_SETTLE, 16: cycles after reset release before straps are sampled; minimum 1.
- STRAP_BOOTSEL_IDX, 45: pad index of bootsel.
- STRAP_STM_IDX, 44: pad index of stm.

Ports:
- clk_i, in, 1: single clock for all logic.
- rst_i, in, 1: asynchronous, active-high reset.
- pad_in_i, in, N_IO: raw pad inputs, asynchronous to clk_i.
- pad_cfg_i, in, N_IO x NBIT_PADCFG: per-pad config. Bit 1 = filter enable. Other bits are ignored.
- deb_limit_i, in, DEB_CNT_W: global debounce threshold in cycles.
- io_in_o, out, N_IO: conditioned pad values, fed to core io_in_i.
- rise_o, out, N_IO: one-cycle pulse on each 0->1 change of io_in_o.
- fall_o, out, N_IO: one-cycle pulse on each 1->0 change of io_in_o.
- bootsel_o, out, 1: latched bootsel strap.
- stm_o, out, 1: latched stm strap.
- strap_valid_o, out, 1: high once both straps are latched.

Behaviour:
- Reset: all outputs are 0 while rst_i is high. This covers io_in_o, rise_o, fall_o, bootsel_o, stm_o and strap_valid_o. All synchroniser flops, counters and FSM state also clear.
- Reset mid-operation: asserting rst_i at any time clears everything immediately. strap_valid_o drops and straps are re-captured after the next release.
- Synchroniser: s = pad_in_i delayed by SYNC_STAGES flops.
- Filter disabled (cfg[1]=0): io_in_o <= s every cycle. Total latency from pad_in_i is SYNC_STAGES+1 cycles. The counter is held at 0.
- Filter enabled, s != io_in_o: the counter increments.
  - When counter+1 >= max(deb_limit_i, 1), io_in_o toggles on that edge and the counter clears.
- Filter enabled, s == io_in_o: the counter clears. This rejects the glitch.
- Counter saturation: the counter saturates at all-ones and cannot wrap.
- Threshold of 0 or 1: deb_limit_i = 0 is treated as 1, which gives the same timing as filter disabled.
- Filter disabled mid-count: the counter clears and io_in_o takes s on the next edge.
- deb_limit_i lowered mid-count: takes effect on the same cycle, because the comparison is combinational.
- Edges: rise_o[i] = io_in_o[i] & ~io_in_q[i] and fall_o[i] = ~io_in_o[i] & io_in_q[i], both registered. They pulse on the cycle after io_in_o changes.
- Strap FSM states: RESET -> SETTLE -> CAPTURE -> DONE.
  - RESET is the reset state; move to SETTLE on the first clock after rst_i deasserts.
  - SETTLE counts STRAP_SETTLE cycles, then moves to CAPTURE.
  - CAPTURE latches bootsel_o = io_in_o[STRAP_BOOTSEL_IDX] and stm_o = io_in_o[STRAP_STM_IDX], then moves to DONE.
  - DONE sets strap_valid_o = 1. Straps hold until reset; later pad changes do not affect them.
- Simultaneous events: a pad change during CAPTURE is sampled as the io_in_o value on that edge. Strap pads are filtered according to their own cfg bit.

Optional Feature:
- Macro: PAD_INPUT_FILTER_GLITCH_CNT_EN.
- When defined, add:
  - glitch_cnt_o, out, 16: saturating count of rejected glitches across all pads. A rejection is a filtered pad whose counter clears while nonzero without io_in_o toggling. Multiple rejections in one cycle add their popcount.
  - glitch_clr_i, in, 1: synchronous clear of glitch_cnt_o. It takes priority over a same-cycle increment.
  - glitch_cnt_o resets to 0.
- When undefined, neither port nor the counter logic exists.

Decomposition:
- pad_input_filter_pkg holds:
  - strap_state_e enum (RESET, SETTLE, CAPTURE, DONE);
  - PADCFG_FILT_EN_BIT = 1;
  - GLITCH_CNT_W = 16.
- Sub-module pad_debounce_cell: synchroniser, counter, io_in register and edge flops for one pad, instantiated N_IO times with a generate loop.
- Top level: threshold clamp, strap FSM and the optional glitch popcount/counter.

Test Plan:
- Filter off, pad_in_i[5] 0->1 -> io_in_o[5]=1 exactly 3 cycles later (SYNC_STAGES=2); rise_o[5] pulses 1 cycle at cycle 4.
- Filter on pad 10, deb_limit_i=4, 3-cycle high glitch -> io_in_o[10] stays 0. With GLITCH_CNT_EN, glitch_cnt_o=1.
- Filter on, deb_limit_i=4, sustained high -> io_in_o toggles at cycle 2+4=6 after the pad change; fall_o on release mirrors the same timing.
- Pads 45=1 and 44=0 held through reset; release rst_i -> strap_valid_o rises at cycle STRAP_SETTLE+2 with bootsel_o=1, stm_o=0. Toggling pad 45 afterwards leaves bootsel_o=1.
- Assert rst_i mid-debounce and after DONE -> all outputs 0 asynchronously; re-capture after release shows the new strap values.
- deb_limit_i=0 with filter on -> timing identical to filter off. glitch_clr_i with a simultaneous glitch -> glitch_cnt_o=0.
